seven_segment_scan: RTL and testbench
=====================================

# seven_segment_scan

Time-multiplexed driver for an N-digit common-anode seven-segment display with per-digit decimal points. A frame-synchronous shadow register prevents tearing, optional hex decode and leading-zero blanking are supported, and an anti-ghosting blank interval separates digit slots. It sits between datapath logic producing packed BCD/hex nibbles and the board display pins, replacing per-digit static decoders.

## Interface
- NUM_DIGITS, 4: digits driven; legal range 1..8.
- CLK_DIV, 100000: clock cycles per digit slot; must be ≥ 2.
- BLANK_CYC, 16: cycles at the start of each slot with all anodes off; must be < CLK_DIV.
- HEX_EN, 1: 1 = nibbles 10..15 show A,b,C,d,E,F; 0 = they show blank.
- LZ_BLANK, 1: 1 = leading-zero blanking enabled.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- digits  in  4*NUM_DIGITS  nibble per digit; digit 0 (rightmost) is in [3:0].
- dp  in  NUM_DIGITS  decimal point per digit; 1 = lit.
- load  in  1  one-cycle strobe; captures digits/dp into pending register.
- seg  out  7  active-low segments, bit6 = a … bit0 = g.
- dp_n  out  1  active-low decimal point.
- an  out  NUM_DIGITS  active-low anode enables, one-hot-low or all-high.
- frame_done  out  1  one-cycle pulse at each frame start.

## Operation
- Counters: slot counter cnt runs 0..CLK_DIV-1 and wraps. Digit index idx advances on the edge where cnt wraps, from NUM_DIGITS-1 to 0.
- Shadow registers:
  - load=1 writes pending ← {digits, dp}.
  - On the edge where idx wraps to 0: active ← pending (the pre-edge value) and frame_done pulses.
  - When load and the wrap coincide, active takes the old pending and the new data appears one frame later.
  - With NUM_DIGITS=1, every slot wrap is a frame wrap.
- Decode: nibble is active digit idx.
  - Codes 0–9 use the canonical active-low patterns: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  - A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
  - Blank is 1111111.
- Leading-zero blank (LZ_BLANK=1): a digit i>0 whose nibble is 0 and all of whose higher digits are 0 shows blank segments. Digit 0 is never blanked. dp is unaffected by blanking.
- Outputs during a slot:
  - While cnt < BLANK_CYC: an all ones, seg=1111111, dp_n=1.
  - Otherwise: an bit idx = 0 and others 1, seg = decode, dp_n = ~dp[idx].

## Timing
- All outputs are registered and computed from next-state values, so an, seg and dp_n change on the same edge as cnt/idx.
- Reset (rst=0 at an edge): cnt=0, idx=0, pending=0, active=0, seg=1111111, dp_n=1, an all ones, frame_done=0. Reset mid-frame aborts the frame immediately.
- First edge after reset release: cnt=1. The first frame displays active=0 (shown as "0" on digit 0; other digits blank when LZ_BLANK=1), and load data is visible from frame 2.
- frame_done is high for exactly the cycle after the wrap edge.
- Latency from load to visible: between 1 and NUM_DIGITS*CLK_DIV cycles plus 1, depending on frame position.
- Frame period is exactly NUM_DIGITS*CLK_DIV cycles.

## Structure
- Package seg7_pkg holds:
  - the segment constants (SEG_BLANK, SEG_0..SEG_F);
  - typedef seg7_t (logic [6:0]);
  - typedef nibble_t (logic [3:0]).
- Sub-module seg7_hex_decode (combinational, parameter HEX_EN): nibble_t and blank in, seg7_t out.
- Top-level logic: counters, shadow registers, leading-zero mask computed over active, output registers.

## Test plan
Parameters for all scenarios: NUM_DIGITS=4, CLK_DIV=4, BLANK_CYC=1.
- Reset: hold rst=0 for 3 cycles -> seg=1111111, an=1111, dp_n=1, frame_done=0. After release, frame 1 shows an=1110/seg=0000001 in cycles with cnt≥1, and digits 1–3 are blank.
- Load digits=16'h1234, dp=0100 mid-frame 1 -> frame 2 scans digit0 seg=1001100, digit1 0000110, digit2 0010010 with dp_n=0, digit3 1001111. Each slot has exactly 1 cycle of an=1111.
- LZ blank: digits=16'h0050, LZ_BLANK=1 -> digits 3 and 2 seg=1111111, digit1=0100100, digit0=0000001. With LZ_BLANK=0, digits 3 and 2 show 0000001.
- Hex mode: digits=16'hABCF with HEX_EN=1 -> F,C,b,A patterns per digit. With HEX_EN=0 all four digits show 1111111.
- Collision: assert load on the exact frame-wrap edge with new value 16'h9999 -> the next frame shows the prior pending value, and 9999 appears in the frame after that. frame_done pulses every 16 cycles.
- Mid-frame reset: rst=0 during idx=2 -> outputs return to reset values on that edge, and the scan restarts at idx=0 with pending/active cleared.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and active-low segment patterns (bit6 = a ... bit0 = g).
package seg7_pkg;

    typedef logic [6:0] seg7_t;
    typedef logic [3:0] nibble_t;

    localparam seg7_t SEG_BLANK = 7'b1111111;
    localparam seg7_t SEG_0     = 7'b0000001;
    localparam seg7_t SEG_1     = 7'b1001111;
    localparam seg7_t SEG_2     = 7'b0010010;
    localparam seg7_t SEG_3     = 7'b0000110;
    localparam seg7_t SEG_4     = 7'b1001100;
    localparam seg7_t SEG_5     = 7'b0100100;
    localparam seg7_t SEG_6     = 7'b0100000;
    localparam seg7_t SEG_7     = 7'b0001111;
    localparam seg7_t SEG_8     = 7'b0000000;
    localparam seg7_t SEG_9     = 7'b0000100;
    localparam seg7_t SEG_A     = 7'b0001000;
    localparam seg7_t SEG_B     = 7'b1100000;
    localparam seg7_t SEG_C     = 7'b0110001;
    localparam seg7_t SEG_D     = 7'b1000010;
    localparam seg7_t SEG_E     = 7'b0110000;
    localparam seg7_t SEG_F     = 7'b0111000;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble-to-segment decoder. Letters A..F are shown only
// when HEX_EN is set; otherwise those codes fall back to a dark digit.
module seg7_hex_decode
    import seg7_pkg::*;
#(
    parameter bit HEX_EN = 1'b1
) (
    input  nibble_t nib_i,
    input  logic    blank_i,
    output seg7_t   seg_o
);

    // Pattern lookup; a forced blank overrides every code.
    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (nib_i)
                4'h0:    seg_o = SEG_0;
                4'h1:    seg_o = SEG_1;
                4'h2:    seg_o = SEG_2;
                4'h3:    seg_o = SEG_3;
                4'h4:    seg_o = SEG_4;
                4'h5:    seg_o = SEG_5;
                4'h6:    seg_o = SEG_6;
                4'h7:    seg_o = SEG_7;
                4'h8:    seg_o = SEG_8;
                4'h9:    seg_o = SEG_9;
                4'hA:    seg_o = HEX_EN ? SEG_A : SEG_BLANK;
                4'hB:    seg_o = HEX_EN ? SEG_B : SEG_BLANK;
                4'hC:    seg_o = HEX_EN ? SEG_C : SEG_BLANK;
                4'hD:    seg_o = HEX_EN ? SEG_D : SEG_BLANK;
                4'hE:    seg_o = HEX_EN ? SEG_E : SEG_BLANK;
                4'hF:    seg_o = HEX_EN ? SEG_F : SEG_BLANK;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/seven_segment_scan.sv
// Time-multiplexed common-anode seven-segment driver. Data is captured into
// a pending register on load and promoted to the displayed (active) copy only
// at frame wrap, so a frame never mixes old and new digits. Each digit slot
// starts with a short all-anodes-off interval to suppress ghosting.
// Outputs are registered from next-state values so they move with cnt/idx.
module seven_segment_scan
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 100000,
    parameter int BLANK_CYC  = 16,
    parameter bit HEX_EN     = 1'b1,
    parameter bit LZ_BLANK   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;

    logic [NUM_DIGITS-1:0][3:0] pend_dig_q, pend_dig_d;
    logic [NUM_DIGITS-1:0]      pend_dp_q,  pend_dp_d;
    logic [NUM_DIGITS-1:0][3:0] act_dig_q,  act_dig_d;
    logic [NUM_DIGITS-1:0]      act_dp_q,   act_dp_d;

    seg7_t                 seg_q, seg_d;
    logic                  dp_n_q, dp_n_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  fd_q, fd_d;

    logic                  slot_wrap, frame_wrap;
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  zero_above;
    seg7_t                 dec_seg;

    // Slot/digit counters and shadow-register transfer.
    always_comb begin
        slot_wrap  = (cnt_q == CNT_LAST);
        frame_wrap = slot_wrap && (idx_q == IDX_LAST);

        cnt_d = slot_wrap ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (slot_wrap) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

        // Promotion uses the pre-edge pending copy, so a load landing on the
        // wrap edge is shown one frame later.
        act_dig_d = frame_wrap ? pend_dig_q : act_dig_q;
        act_dp_d  = frame_wrap ? pend_dp_q  : act_dp_q;
        pend_dig_d = load ? digits : pend_dig_q;
        pend_dp_d  = load ? dp     : pend_dp_q;

        fd_d = frame_wrap;
    end

    // Leading-zero mask over the next active value, scanning from the top
    // digit down; digit 0 is never masked.
    always_comb begin
        lz_mask    = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_above = zero_above && (act_dig_d[i] == 4'h0);
            lz_mask[i] = LZ_BLANK && zero_above;
        end
    end

    seg7_hex_decode #(.HEX_EN(HEX_EN)) u_dec (
        .nib_i   (act_dig_d[idx_d]),
        .blank_i (lz_mask[idx_d]),
        .seg_o   (dec_seg)
    );

    // Next output values: dark during the anti-ghost window, else drive idx.
    always_comb begin
        an_d   = '1;
        seg_d  = SEG_BLANK;
        dp_n_d = 1'b1;
        if (cnt_d >= BLANK_END) begin
            an_d   = ~(NUM_DIGITS'(1) << idx_d);
            seg_d  = dec_seg;
            dp_n_d = ~act_dp_d[idx_d];
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            pend_dig_q <= '0;
            pend_dp_q  <= '0;
            act_dig_q  <= '0;
            act_dp_q   <= '0;
            seg_q      <= SEG_BLANK;
            dp_n_q     <= 1'b1;
            an_q       <= '1;
            fd_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            pend_dig_q <= pend_dig_d;
            pend_dp_q  <= pend_dp_d;
            act_dig_q  <= act_dig_d;
            act_dp_q   <= act_dp_d;
            seg_q      <= seg_d;
            dp_n_q     <= dp_n_d;
            an_q       <= an_d;
            fd_q       <= fd_d;
        end
    end

    assign seg        = seg_q;
    assign dp_n       = dp_n_q;
    assign an         = an_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Bench for seven_segment_scan: three parameter variants share one stimulus
// stream and are compared every cycle against a time-indexed display model.
module tb_seven_segment_scan;

    localparam int ND = 4;
    localparam int CD = 4;
    localparam int BC = 1;
    localparam int FP = ND * CD;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [15:0]   digits = '0;
    logic [3:0]    dp = '0;
    logic          load = 1'b0;

    logic [6:0] seg_a, seg_b, seg_c;
    logic       dpn_a, dpn_b, dpn_c;
    logic [3:0] an_a, an_b, an_c;
    logic       fd_a, fd_b, fd_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seven_segment_scan #(.NUM_DIGITS(ND), .CLK_DIV(CD), .BLANK_CYC(BC),
                         .HEX_EN(1'b1), .LZ_BLANK(1'b1)) u_a (
        .clk(clk), .rst(rst), .digits(digits), .dp(dp), .load(load),
        .seg(seg_a), .dp_n(dpn_a), .an(an_a), .frame_done(fd_a));

    seven_segment_scan #(.NUM_DIGITS(ND), .CLK_DIV(CD), .BLANK_CYC(BC),
                         .HEX_EN(1'b1), .LZ_BLANK(1'b0)) u_b (
        .clk(clk), .rst(rst), .digits(digits), .dp(dp), .load(load),
        .seg(seg_b), .dp_n(dpn_b), .an(an_b), .frame_done(fd_b));

    seven_segment_scan #(.NUM_DIGITS(ND), .CLK_DIV(CD), .BLANK_CYC(BC),
                         .HEX_EN(1'b0), .LZ_BLANK(1'b1)) u_c (
        .clk(clk), .rst(rst), .digits(digits), .dp(dp), .load(load),
        .seg(seg_c), .dp_n(dpn_c), .an(an_c), .frame_done(fd_c));

    // Reference patterns indexed by nibble value.
    localparam logic [6:0] TBL [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    // Model: cycles elapsed since reset plus the two data copies.
    int          t;
    logic [15:0] m_pend, m_act;
    logic [3:0]  m_pdp, m_adp;
    logic        m_fd;

    function automatic logic [6:0] exp_seg(logic [15:0] v, int i, bit hex, bit lz);
        logic [15:0] above;
        logic [3:0]  nib;
        above = v >> (4 * i);
        nib   = above[3:0];
        if (lz && i > 0 && above == 16'h0) return 7'h7F;
        if (!hex && nib >= 4'd10) return 7'h7F;
        return TBL[nib];
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    task automatic check_all();
        int         c, i;
        bit         vis;
        logic [3:0] e_an;
        logic       e_dpn;
        c   = t % CD;
        i   = (t / CD) % ND;
        vis = (c >= BC);
        e_an  = vis ? ~(4'b0001 << i) : 4'hF;
        e_dpn = vis ? ~m_adp[i] : 1'b1;
        chk("an_a", 32'(an_a), 32'(e_an));
        chk("an_b", 32'(an_b), 32'(e_an));
        chk("an_c", 32'(an_c), 32'(e_an));
        chk("dpn_a", 32'(dpn_a), 32'(e_dpn));
        chk("dpn_c", 32'(dpn_c), 32'(e_dpn));
        chk("seg_hex_lz", 32'(seg_a), 32'(vis ? exp_seg(m_act, i, 1, 1) : 7'h7F));
        chk("seg_hex_nolz", 32'(seg_b), 32'(vis ? exp_seg(m_act, i, 1, 0) : 7'h7F));
        chk("seg_nohex_lz", 32'(seg_c), 32'(vis ? exp_seg(m_act, i, 0, 1) : 7'h7F));
        chk("frame_done_a", 32'(fd_a), 32'(m_fd));
        chk("frame_done_b", 32'(fd_b), 32'(m_fd));
    endtask

    // One clock edge: capture pre-edge inputs, advance the model, compare.
    task automatic cycle();
        logic        r, l, w;
        logic [15:0] dg;
        logic [3:0]  d;
        r = rst; l = load; dg = digits; d = dp;
        @(posedge clk);
        #1;
        if (!r) begin
            t = 0; m_pend = '0; m_act = '0; m_pdp = '0; m_adp = '0; m_fd = 1'b0;
        end else begin
            w = ((t % FP) == FP - 1);
            if (w) begin m_act = m_pend; m_adp = m_pdp; end
            if (l) begin m_pend = dg; m_pdp = d; end
            t++;
            m_fd = w;
        end
        check_all();
    endtask

    task automatic run(int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic do_load(logic [15:0] v, logic [3:0] d);
        digits = v; dp = d; load = 1'b1;
        cycle();
        load = 1'b0;
    endtask

    task automatic wait_phase(int ph);
        int n;
        n = 0;
        while ((t % FP) != ph && n < FP) begin cycle(); n++; end
        chk("phase_reached", 32'(t % FP), 32'(ph));
    endtask

    initial begin
        t = 0; m_pend = '0; m_act = '0; m_pdp = '0; m_adp = '0; m_fd = 1'b0;

        // Reset held for three cycles.
        rst = 1'b0;
        run(3);
        rst = 1'b1;

        // Frame 1 shows zero on digit 0; load mid-frame, visible in frame 2.
        run(5);
        do_load(16'h1234, 4'b0100);
        run(2 * FP);

        // Leading-zero blanking.
        do_load(16'h0050, 4'b0001);
        run(2 * FP);

        // Hex letters (and their suppression in the non-hex variant).
        do_load(16'hABCF, 4'b1010);
        run(2 * FP);

        // Load landing exactly on the frame-wrap edge.
        do_load(16'h1111, 4'b0000);
        wait_phase(FP - 1);
        do_load(16'h9999, 4'b1111);
        run(3 * FP);

        // Reset while digit 2 is being scanned.
        wait_phase(9);
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        run(FP + 4);

        // Random traffic with zero-heavy nibbles and occasional resets.
        for (int k = 0; k < 600; k++) begin
            logic [15:0] v;
            for (int j = 0; j < 4; j++)
                v[4*j +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            digits = v;
            dp     = 4'($urandom_range(0, 15));
            load   = ($urandom_range(0, 7) == 0);
            rst    = ($urandom_range(0, 149) != 0);
            cycle();
        end
        rst = 1'b1;
        load = 1'b0;
        run(2 * FP);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
